// File: rtl/toy_bus_req_fifo.sv
// toy_bus_req_fifo: in-order request buffer between the LSU/debug arbiter and
// the target-side bus stage. in_rdy and out_vld come straight from flops, so
// out_rdy never reaches the arbiter combinationally.
module toy_bus_req_fifo #(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_vld,
  output logic          in_rdy,
  input  logic [31:0]   in_addr,
  input  logic [3:0]    in_strb,
  input  logic [31:0]   in_data,
  input  logic          in_opcode,
  input  logic [3:0]    in_src_id,
  input  logic [3:0]    in_tgt_id,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic [31:0]   out_addr,
  output logic [3:0]    out_strb,
  output logic [31:0]   out_data,
  output logic          out_opcode,
  output logic [3:0]    out_src_id,
  output logic [3:0]    out_tgt_id,
  output logic [CW-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = 77;

  logic [PW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [CW-1:0] r_count;
  logic          r_in_rdy;
  logic          r_out_vld;

  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_count_nxt;
  logic [PW-1:0] w_in_payload;
  logic [PW-1:0] w_head;

  assign w_push       = in_vld & r_in_rdy;
  assign w_pop        = r_out_vld & out_rdy;
  assign w_in_payload = {in_addr, in_strb, in_data, in_opcode, in_src_id, in_tgt_id};
  assign w_head       = r_mem[r_rp];

  // Next occupancy: simultaneous push and pop cancel out.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Payload storage; the slot at wp is written on every accepted push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wp] <= w_in_payload;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
    end
  end

  // Occupancy plus flag flops precomputed from next occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count   <= '0;
      r_in_rdy  <= 1'b1;
      r_out_vld <= 1'b0;
    end else begin
      r_count   <= w_count_nxt;
      r_in_rdy  <= (w_count_nxt != CW'(DEPTH));
      r_out_vld <= (w_count_nxt != CW'(0));
    end
  end

  assign in_rdy     = r_in_rdy;
  assign out_vld    = r_out_vld;
  assign count      = r_count;
  assign out_addr   = w_head[76:45];
  assign out_strb   = w_head[44:41];
  assign out_data   = w_head[40:9];
  assign out_opcode = w_head[8];
  assign out_src_id = w_head[7:4];
  assign out_tgt_id = w_head[3:0];

endmodule

// File: doc/toy_bus_req_fifo.md
# toy_bus_req_fifo

Request buffer on the ToyBusReq path, sitting directly downstream of the two-input LSU/debug request arbiter. It accepts the arbiter's granted request on a valid/ready handshake, stores up to DEPTH requests in order, and presents them to the target-side bus stage. Its registered ready cuts the combinational out_rdy → arbiter age-matrix update path. Its storage absorbs target back-pressure bursts.

## Interface
- DEPTH, 4, number of entries; power of two, ≥ 2
- CW, log2(DEPTH)+1 = 3, width of count (derived, not overridable)

- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- in_vld  in  1  request valid from arbiter
- in_rdy  out  1  buffer can accept; registered-state derived
- in_addr  in  32  byte address
- in_strb  in  4  byte strobes
- in_data  in  32  write data
- in_opcode  in  1  0 = read, 1 = write
- in_src_id  in  4  requester id
- in_tgt_id  in  4  target id
- out_vld  out  1  head entry valid
- out_rdy  in  1  downstream accepts
- out_addr, out_strb, out_data, out_opcode, out_src_id, out_tgt_id  out  32/4/32/1/4/4  head entry payload
- count  out  CW  number of occupied entries, 0..DEPTH

## Operation
- Storage is a DEPTH-entry register array of 77-bit payloads {addr, strb, data, opcode, src_id, tgt_id}.
- Write pointer wp and read pointer rp are each log2(DEPTH) bits and wrap modulo DEPTH. Occupancy is count, CW bits.
- push = in_vld & in_rdy: the entry at wp takes the in_* payload, and wp increments.
- pop = out_vld & out_rdy: rp increments.
- count update: count+1 on push only, count−1 on pop only, unchanged on both or neither.
- in_rdy = (count != DEPTH). It depends only on flops, with no path from out_rdy or in_vld.
- out_vld = (count != 0). out_* = storage[rp], with no bypass from the input.
- Full with simultaneous pop: in_rdy = 0, so no push occurs in that cycle. The freed slot is offered on the next cycle.
- Empty with push: out_vld rises on the next cycle, not the same one.
- Push and pop in the same cycle at 0 < count < DEPTH: both take effect, and count is unchanged.
- While out_vld = 1 and out_rdy = 0, out_* and out_vld hold stable until the pop.
- Data is never reordered, dropped or duplicated. Payload bits pass through unmodified.
- The block does not inspect opcode or ids.

## Timing
- Reset (rst = 1, asynchronous) values:
  - wp = rp = 0, count = 0, all storage entries = 0.
  - out_vld = 0, in_rdy = 1, all out_* = 0.
- Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge. The first push after rst deasserts behaves as in the empty case.
- Latency from push at edge N to out_vld/out_* at the output: 1 cycle (visible after edge N).
- Sustained throughput is one request per cycle when out_rdy is held high and in_vld is continuous. After the first-entry latency, count stays at 1.
- in_rdy falls in the cycle after the push that makes count = DEPTH. It rises in the cycle after the first pop from full.
- count is a registered output that reflects post-edge state.

## Test plan
- Reset/idle:
  - Assert rst mid-simulation, asynchronously between edges → out_vld = 0, in_rdy = 1, count = 0 immediately.
  - Deassert, with in_vld = 0 → outputs stay the same for 10 cycles.
- Single pass:
  - Push {addr = 0x1000_0040, strb = 0xF, data = 0xDEAD_BEEF, opcode = 1, src = 2, tgt = 5} with out_rdy = 0.
  - Next cycle: out_vld = 1 with identical payload, count = 1.
  - Raise out_rdy → pop; next cycle out_vld = 0, count = 0.
- Fill and wrap:
  - With out_rdy = 0, push 4 requests with data 1..4 → count = 4, in_rdy = 0. A 5th in_vld is not accepted.
  - Pop 2, then push data 5, 6 → pops yield 1, 2, 3, 4, 5, 6 in order, exercising pointer wrap.
- Full with simultaneous pop:
  - At count = 4 with out_rdy = 1 and in_vld = 1 → that cycle in_rdy = 0 and only the pop occurs (count = 3).
  - Next cycle in_rdy = 1 and the push is accepted.
- Streaming:
  - 100 back-to-back pushes with incrementing data, out_rdy = 1 throughout → every value is delivered exactly once, in order.
  - count ≤ 1 throughout; in_rdy is never low.
- Random back-pressure:
  - 1000 transactions with random in_vld/out_rdy at 50% each → a scoreboard sees in-order, lossless delivery.
  - out_* are stable during every stall; count always equals pushes − pops.
